// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline hazard inputs and stall/flush outputs.
// The pipeline side (master) drives the decode/execute fields; the
// controller (slave) drives the hold, bubble, flush and mul/div status.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             jr;
    logic             jal;
    logic             branch_taken;
    logic             md_start;
    logic             md_div;
    logic             lu_hazard;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             md_stall;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd, jr, jal,
               branch_taken, md_start, md_div,
        input  lu_hazard, id_ex_bubble, if_id_flush, md_stall, md_busy,
               md_done, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd, jr, jal,
               branch_taken, md_start, md_div,
        output lu_hazard, id_ex_bubble, if_id_flush, md_stall, md_busy,
               md_done, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use detection, branch/jump flushing and
// a multi-cycle mul/div sequencer that freezes the pipeline while busy.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no mul/div in flight; md_start launches one
// BUSY  | mul/div in flight; cnt counts down to 0, pipeline frozen
// DONE  | one-cycle result-ready pulse, then back to IDLE
module hazard_ctrl #(
    parameter int MUL_CYC = 4,
    parameter int DIV_CYC = 32,
    parameter int CNT_W   = 16
) (
    input logic           clk,
    input logic           rst,
    hazard_ctrl_if.slave  hz
);
    localparam int LAT_MAX = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
    localparam int CYC_W   = (LAT_MAX > 2) ? $clog2(LAT_MAX) : 1;
    // BUSY lasts load+1 cycles and DONE one more, so loading LAT-2 gives
    // exactly LAT cycles from md_start to md_done.
    localparam logic [CYC_W-1:0] MUL_LOAD = CYC_W'(MUL_CYC - 2);
    localparam logic [CYC_W-1:0] DIV_LOAD = CYC_W'(DIV_CYC - 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CYC_W-1:0] cnt;
    logic [CYC_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             luh;
    logic             busy;

    // State, countdown and saturating stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if ((hz.lu_hazard || hz.md_stall) && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Mul/div sequencing; md_start outside IDLE is dropped, never queued.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (hz.md_start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = hz.md_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - CYC_W'(1);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Register 0 is hardwired, so a load targeting it is never a hazard.
    assign luh = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                 ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
    assign busy = (state == BUSY);

    // Prioritised hazard outputs: mul/div freeze > branch > load-use > jr/jal.
    always_comb begin
        hz.lu_hazard    = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.md_stall     = 1'b0;
        hz.md_busy      = 1'b0;
        hz.md_done      = 1'b0;
        if (!rst) begin
            hz.md_busy  = busy;
            hz.md_stall = busy;
            hz.md_done  = (state == DONE);
            if (busy) begin
                // pipeline frozen: every other request is masked
            end else if (hz.branch_taken) begin
                hz.if_id_flush  = 1'b1;
                hz.id_ex_bubble = 1'b1;
            end else if (luh) begin
                // IF/ID is held, so a coincident jr/jal is seen again next cycle
                hz.lu_hazard    = 1'b1;
                hz.id_ex_bubble = 1'b1;
            end else if (hz.jr || hz.jal) begin
                hz.if_id_flush  = 1'b1;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt;
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL use one clock and one reset: synchronous, active-high; all state updates on the clk rising edge only.
REQ-002 SHALL have parameters (name, default, meaning):
- MUL_CYC, 4: multiply latency in cycles
- DIV_CYC, 32: divide latency in cycles
- CNT_W, 16: stall-counter width
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: clock
- rst, in, 1: sync reset, active-high
- id_rs, in, 5: IF/ID rs field
- id_rt, in, 5: IF/ID rt field
- id_uses_rt, in, 1: ID instruction reads rt
- ex_mem_read, in, 1: EX instruction is a load
- ex_rd, in, 5: EX destination register
- jr, in, 1: jump-register decoded in ID
- jal, in, 1: jal decoded in ID
- branch_taken, in, 1: branch resolved taken in EX
- md_start, in, 1: mul/div issued into EX
- md_div, in, 1: 1 = divide, 0 = multiply; valid with md_start
- lu_hazard, out, 1: hold PC and IF/ID
- id_ex_bubble, out, 1: insert NOP into ID/EX
- if_id_flush, out, 1: clear IF/ID
- md_stall, out, 1: freeze PC, IF/ID and ID/EX
- md_busy, out, 1: FSM is in BUSY
- md_done, out, 1: one-cycle result-ready pulse
- stall_cnt, out, CNT_W: total stall cycles, saturating

Function
REQ-004 SHALL implement FSM states IDLE, BUSY, DONE in a registered state register.
REQ-005 IDLE -> BUSY when md_start=1; cnt loads DIV_CYC-2 if md_div=1, else MUL_CYC-2.
REQ-006 In BUSY, cnt decrements by 1 per cycle; BUSY -> DONE when cnt==0.
REQ-007 DONE -> IDLE unconditionally after one cycle; md_start sampled in DONE starts no operation.
REQ-008 md_start SHALL be ignored in BUSY and DONE; no queueing.
REQ-009 Total cycles from md_start to the md_done pulse SHALL equal MUL_CYC or DIV_CYC, inclusive of the BUSY cycles plus the DONE cycle.
REQ-010 md_busy = (state==BUSY); md_stall = md_busy; md_done = (state==DONE); all are combinational decodes of registered state.
REQ-011 Load-use detect (combinational) SHALL be: luh = ex_mem_read and ex_rd!=0 and (ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt)).
REQ-012 Output priority SHALL be md_stall > branch_taken > luh > jr/jal.
REQ-013 While md_stall=1: lu_hazard=0, id_ex_bubble=0, if_id_flush=0; the pipeline is frozen and all other requests are masked.
REQ-014 When branch_taken=1 and md_stall=0: if_id_flush=1, id_ex_bubble=1, lu_hazard=0.
REQ-015 When luh=1 and branch_taken=0 and md_stall=0: lu_hazard=1, id_ex_bubble=1, if_id_flush=0.
REQ-016 When (jr or jal)=1 with no higher-priority condition: if_id_flush=1 only.
REQ-017 When jr/jal and luh coincide, the luh outcome wins; jr/jal is re-evaluated on the next cycle because IF/ID is held.
REQ-018 stall_cnt SHALL increment by 1 each cycle that lu_hazard or md_stall is 1, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-019 Register 0 SHALL never cause a load-use hazard.

Reset
REQ-020 On rst=1: state=IDLE, cnt=0, stall_cnt=0; consequently md_busy=0, md_stall=0, md_done=0.
REQ-021 rst mid-BUSY SHALL abort the operation; no md_done pulse follows.
REQ-022 Combinational outputs during rst SHALL be forced to 0.

Verification
REQ-023 Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 -> lu_hazard=1, id_ex_bubble=1, stall_cnt increments 0->1; repeat with ex_rd=0 -> no hazard.
REQ-024 Multiply: md_start=1, md_div=0 at cycle 0 -> md_stall=1 in cycles 1-3, md_done=1 in cycle 4, IDLE in cycle 5, stall_cnt=3.
REQ-025 Divide with interference: md_div=1, plus luh=1 and branch_taken=1 during BUSY -> only md_stall=1 for cycles 1-31, md_done in cycle 32, no flush or bubble.
REQ-026 Priority: branch_taken=1 and luh=1 in the same cycle -> if_id_flush=1, id_ex_bubble=1, lu_hazard=0; jal=1 with luh=1 -> lu_hazard=1, if_id_flush=0.
REQ-027 Reset abort: rst=1 at BUSY cycle 10 of a divide -> next cycle state=IDLE, md_stall=0, stall_cnt=0, no md_done pulse.
REQ-028 Saturation: CNT_W=4 with 20 consecutive stall cycles -> stall_cnt holds at 15.
